// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The JAL predictor helper is only used when FETCH_JAL_PREDICT_EN is defined.
package inst_fetcher_pkg;

  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam logic [6:0] JAL_TYPE = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pred_pc;
  } iq_entry_t;

  function automatic logic [31:0] jal_imm(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetcher_queue.sv
// Circular FIFO of {inst, pc, pred_pc} entries; clear has priority over push/pop.
// The caller never pushes when full and never pops when empty.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  logic      i_pop,
  input  logic      i_clear,
  input  iq_entry_t i_wdata,
  output logic      o_full,
  output logic      o_empty,
  output iq_entry_t o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  iq_entry_t     r_mem [DEPTH];

  // Pointers, occupancy and storage; the head entry reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_wdata;
        r_tail        <= r_tail + PW'(1);
      end
      if (i_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == CW'(0));
  assign o_head  = r_mem[r_head];

endmodule

// File: rtl/inst_fetcher.sv
// Fetch front end: owns the PC, issues one ICache request at a time, queues words for decode.
// Define FETCH_JAL_PREDICT_EN to predict JAL targets; otherwise every word predicts pc+4.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int          IQ_DEPTH = 16,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  output logic        icache_req_valid,
  output logic [31:0] icache_req_addr,
  input  logic        icache_rsp_valid,
  input  logic [31:0] icache_rsp_inst,
  input  logic        flush_in,
  input  logic [31:0] flush_pc,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pred_pc,
  input  logic        inst_ready
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_pred_pc;
  logic         w_full;
  logic         w_empty;
  logic         w_issue;
  logic         w_push;
  logic         w_pop;
  logic         w_clear;
  iq_entry_t    w_push_data;
  iq_entry_t    w_head;

  assign w_issue = (r_state == ST_IDLE) & rdy_in & ~flush_in & ~w_full;
  assign w_push  = (r_state == ST_BUSY) & icache_rsp_valid & rdy_in & ~flush_in;
  assign w_pop   = ~w_empty & inst_ready & rdy_in & ~flush_in;
  assign w_clear = rdy_in & flush_in;

  // Next-PC prediction for the word being returned this cycle.
  always_comb begin
    w_pred_pc = r_pc + 32'd4;
`ifdef FETCH_JAL_PREDICT_EN
    if (icache_rsp_inst[6:0] == JAL_TYPE) begin
      w_pred_pc = r_pc + jal_imm(icache_rsp_inst);
    end else begin
      w_pred_pc = r_pc + 32'd4;
    end
`endif
  end

  assign w_push_data = '{inst: icache_rsp_inst, pc: r_pc, pred_pc: w_pred_pc};

  // State and PC registers; everything holds while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Fetch FSM: flush redirects and, if a request is still in flight, marks it for discard.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    if (!rdy_in) begin
      w_state_nxt = r_state;
    end else if (flush_in) begin
      w_pc_nxt = flush_pc;
      if ((r_state != ST_IDLE) && !icache_rsp_valid) begin
        w_state_nxt = ST_DROP;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            w_state_nxt = ST_BUSY;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (icache_rsp_valid) begin
            w_state_nxt = ST_IDLE;
            w_pc_nxt    = w_pred_pc;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end
        ST_DROP: begin
          if (icache_rsp_valid) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DROP;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  inst_queue #(
    .DEPTH(IQ_DEPTH)
  ) u_queue (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_clear(w_clear),
    .i_wdata(w_push_data),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_head (w_head)
  );

  // The idle state would otherwise request while reset is still asserted.
  assign icache_req_valid = w_issue & rst_n_in;
  assign icache_req_addr  = r_pc;
  assign inst_valid       = ~w_empty;
  assign inst_out         = w_head.inst;
  assign inst_pc          = w_head.pc;
  assign inst_pred_pc     = w_head.pred_pc;

endmodule
